// File: rtl/rv32_imem_responder.sv
// rv32_imem_responder: memory side of the fetch port. Requests are decoded
// and the store is read in the accept cycle. The result passes through
// LATENCY-1 register stages and then into an in-order response FIFO.
// A registered outstanding count limits how many requests are in flight,
// so the FIFO never overflows.
module rv32_imem_responder #(
  parameter int          DEPTH           = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_WORD        = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_instr,
  output logic                     resp_fault,
  output logic [31:0]              resp_addr,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
    logic [31:0] addr;
  } resp_t;

  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          w_accept;
  logic          w_retire;
  logic          w_fault;
  logic          w_push;
  logic [AW-1:0] w_idx;
  resp_t         w_new;
  resp_t         w_fin;
  resp_t         w_head;

  // Ready depends only on the registered count, never on this cycle's
  // handshakes. Holding reset also forces it low.
  assign req_ready = !reset && (r_count < CW'(MAX_OUTSTANDING));
  assign w_accept  = req_valid && req_ready;
  assign w_retire  = resp_valid && resp_ready;

  assign w_idx   = req_addr[AW+1:2];
  assign w_fault = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Decode and read the store in the accept cycle. A same-cycle load is
  // not yet written, so the request sees the old word.
  always_comb begin
    w_new.addr  = req_addr;
    w_new.fault = w_fault;
    w_new.instr = w_fault ? NOP_WORD : r_mem[w_idx];
  end

  // Preload port. Reset does not touch the store.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_idx] <= load_data;
  end

  // Outstanding count: accepted requests that have not yet been retired.
  always_ff @(posedge clk) begin
    if (reset) r_count <= '0;
    else begin
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_fin  = w_new;
      assign w_push = w_accept;
    end else begin : g_pipe
      resp_t              r_pipe [1:LATENCY-1];
      logic [LATENCY-1:1] r_vld_pipe;

      // Valid shift register. The stages always advance and are never
      // stalled by the consumer.
      always_ff @(posedge clk) begin
        if (reset) r_vld_pipe <= '0;
        else begin
          r_vld_pipe[1] <= w_accept;
          for (int i = 2; i <= LATENCY-1; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
      end

      // Data stages. These have no reset because their valid bits gate them.
      always_ff @(posedge clk) begin
        r_pipe[1] <= w_new;
        for (int i = 2; i <= LATENCY-1; i++) r_pipe[i] <= r_pipe[i-1];
      end

      assign w_fin  = r_pipe[LATENCY-1];
      assign w_push = r_vld_pipe[LATENCY-1];
    end
  endgenerate

  resp_t         r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_fcnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_fin;
  end

  // FIFO pointers and occupancy. Reset drops every buffered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push)   r_wptr <= nxt(r_wptr);
      if (w_retire) r_rptr <= nxt(r_rptr);
      case ({w_push, w_retire})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Outputs come from the FIFO head. They read as zero while it is empty,
  // which makes them zero after reset. The head only moves on a retire, so
  // the outputs stay stable under backpressure.
  assign w_head     = r_fifo[r_rptr];
  assign resp_valid = (r_fcnt != '0);
  assign resp_instr = resp_valid ? w_head.instr : 32'h0;
  assign resp_fault = resp_valid ? w_head.fault : 1'b0;
  assign resp_addr  = resp_valid ? w_head.addr  : 32'h0;

endmodule

// File: tb/tb_rv32_imem_responder.sv
// Bench for rv32_imem_responder. Instance 0 uses LATENCY=1 and
// MAX_OUTSTANDING=2; instance 1 uses LATENCY=3 and MAX_OUTSTANDING=4.
// A transaction-level model keeps a queue of expected responses for each
// instance and checks ready, valid and the head response on every cycle.
module tb_rv32_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_instr [2];
  logic        resp_fault [2];
  logic [31:0] resp_addr  [2];
  logic        load_en    [2];
  logic [9:0]  load_idx   [2];
  logic [31:0] load_data  [2];

  always #5 clk = ~clk;

  rv32_imem_responder #(.DEPTH(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_instr(resp_instr[0]),
    .resp_fault(resp_fault[0]), .resp_addr(resp_addr[0]),
    .load_en(load_en[0]), .load_idx(load_idx[0]), .load_data(load_data[0]));

  rv32_imem_responder #(.DEPTH(1024), .LATENCY(3), .MAX_OUTSTANDING(4)) u_b (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_instr(resp_instr[1]),
    .resp_fault(resp_fault[1]), .resp_addr(resp_addr[1]),
    .load_en(load_en[1]), .load_idx(load_idx[1]), .load_data(load_data[1]));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          acc;
  } exp_t;

  logic [31:0] mem [2][1024];
  exp_t        qa  [2][16];
  int          qh [2], qt [2], qn [2], nret [2];
  bit          last_acc [2];
  bit          rnd_rdy  [2];
  int          cyc, n_chk, n_pass, n_fail;
  logic [31:0] pre [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int maxo(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // One clock cycle. Check the outputs against the model, update the model
  // for this cycle's handshakes and loads, then advance past the edge.
  task automatic tick();
    for (int d = 0; d < 2; d++)
      if (rnd_rdy[d]) resp_ready[d] = 1'($urandom_range(0, 1));
    #1;
    for (int d = 0; d < 2; d++) begin
      bit   er, ev, acc, ret;
      exp_t h, e;
      er = !rst && (qn[d] < maxo(d));
      h  = qa[d][qh[d]];
      ev = (qn[d] > 0) && (cyc >= h.acc + lat(d) - 1);
      chk($sformatf("d%0d_req_ready@%0d", d, cyc), 32'(req_ready[d]), 32'(er));
      chk($sformatf("d%0d_resp_valid@%0d", d, cyc), 32'(resp_valid[d]), 32'(ev));
      if (ev) begin
        chk($sformatf("d%0d_resp_instr@%0d", d, cyc), resp_instr[d], h.instr);
        chk($sformatf("d%0d_resp_fault@%0d", d, cyc), 32'(resp_fault[d]), 32'(h.fault));
        chk($sformatf("d%0d_resp_addr@%0d", d, cyc), resp_addr[d], h.addr);
      end
      acc = req_valid[d] && er;
      ret = ev && resp_ready[d];
      last_acc[d] = acc;
      if (rst) begin
        qn[d] = 0; qh[d] = 0; qt[d] = 0;
      end else begin
        if (ret) begin qh[d] = (qh[d] + 1) % 16; qn[d]--; nret[d]++; end
        if (acc) begin
          e.addr  = req_addr[d];
          e.fault = (e.addr % 4 != 0) || (e.addr >= 32'd4096);
          e.instr = e.fault ? 32'h0000_0013 : mem[d][e.addr / 4];
          e.acc   = cyc + 1;
          qa[d][qt[d]] = e;
          qt[d] = (qt[d] + 1) % 16;
          qn[d]++;
        end
      end
      if (load_en[d]) mem[d][load_idx[d]] = load_data[d];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fetch(input int d, input logic [31:0] a);
    int k;
    k = 0;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    do begin tick(); k++; end while (!last_acc[d] && k < 100);
    chk($sformatf("d%0d_fetch_accept_%h", d, a), 32'(last_acc[d]), 32'd1);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int k;
    k = 0;
    while (qn[d] > 0 && k < 300) begin tick(); k++; end
    chk($sformatf("d%0d_drain_empty", d), 32'(qn[d]), 32'd0);
    chk($sformatf("d%0d_drain_valid", d), 32'(resp_valid[d]), 32'd0);
  endtask

  initial begin
    pre = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};
    n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_addr[d] = '0; resp_ready[d] = 0;
      load_en[d] = 0; load_idx[d] = '0; load_data[d] = '0;
      qh[d] = 0; qt[d] = 0; qn[d] = 0; nret[d] = 0; rnd_rdy[d] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d_ready_in_reset", d), 32'(req_ready[d]), 32'd0);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_valid", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("d%0d_rst_instr", d), resp_instr[d], 32'd0);
      chk($sformatf("d%0d_rst_fault", d), 32'(resp_fault[d]), 32'd0);
      chk($sformatf("d%0d_rst_addr", d), resp_addr[d], 32'd0);
      chk($sformatf("d%0d_ready_after_rst", d), 32'(req_ready[d]), 32'd1);
    end

    // Preload both stores. Index 5 of instance 0 gets a fixed known word.
    for (int i = 0; i < 200; i++) begin
      load_en[0] = 1; load_en[1] = 1;
      load_idx[0] = 10'(i); load_idx[1] = 10'(i);
      load_data[0] = (i < 4) ? pre[i] : (i == 5) ? 32'h1234_5678 : $urandom;
      load_data[1] = $urandom;
      tick();
    end
    load_en[0] = 0; load_en[1] = 0;

    // In-order back-to-back fetches.
    resp_ready[0] = 1;
    fetch(0, 32'h0); fetch(0, 32'h4); fetch(0, 32'h8); fetch(0, 32'hC);
    drain(0);

    // A misaligned fetch, then an out-of-range fetch.
    fetch(0, 32'h2); fetch(0, 32'h1000);
    drain(0);

    // Backpressure: only two requests accepted, and the head response holds.
    resp_ready[0] = 0;
    req_valid[0]  = 1;
    req_addr[0]   = 32'h18; tick();
    req_addr[0]   = 32'h1C; tick();
    tick(); tick(); tick();
    chk("bp_outstanding", 32'(qn[0]), 32'd2);
    chk("bp_ready_low", 32'(req_ready[0]), 32'd0);
    chk("bp_head_addr", resp_addr[0], 32'h18);
    req_valid[0]  = 0;
    resp_ready[0] = 1;
    drain(0);

    // A load and a fetch to the same index in one cycle return the old word.
    load_en[0] = 1; load_idx[0] = 10'd5; load_data[0] = 32'hDEAD_BEEF;
    fetch(0, 32'h14);
    load_en[0] = 0;
    chk("collide_old", resp_instr[0], 32'h1234_5678);
    fetch(0, 32'h14);
    drain(0);

    // Reset while two responses are outstanding.
    resp_ready[0] = 0;
    fetch(0, 32'h0); fetch(0, 32'h4);
    tick();
    rst = 1; tick(); rst = 0;
    chk("midrst_valid", 32'(resp_valid[0]), 32'd0);
    chk("midrst_instr", resp_instr[0], 32'd0);
    chk("midrst_addr", resp_addr[0], 32'd0);
    resp_ready[0] = 1;
    repeat (5) tick();
    fetch(0, 32'h0);
    chk("post_rst_store0", resp_instr[0], 32'h0050_0093);
    drain(0);

    // Instance 1: 200 sequential fetches with a random consumer.
    rnd_rdy[1] = 1;
    for (int i = 0; i < 200; i++) fetch(1, 32'(i * 4));
    drain(1);
    chk("b_retired", 32'(nret[1]), 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
